// File: rtl/io_line_pkg.sv
// io_line_pkg: state encoding and default widths shared by the I/O line capture and generator blocks.
package io_line_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, WAIT, ACTIVE, DONE} io_state_e;
    localparam int IO_DLY_W = 21;
    localparam int IO_WID_W = 11;
endpackage

// File: rtl/io_input_sync_filter.sv
// io_input_sync_filter: 2-flop synchronizer plus debounce filter, enabled by IO_IN_DEBOUNCE_EN.
module io_input_sync_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rest_level,
    input  logic i_line_in,
    output logic o_line_f
);
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end
    logic [1:0] r_sync;
    always_ff @(posedge clk)
        r_sync <= !rst ? {2{i_rest_level}} : {r_sync[0], i_line_in};
`ifdef IO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_line_f;
    // The output flips on the DEB_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk)
        if (!rst) begin
            r_line_f <= i_rest_level;
            r_cnt    <= '0;
        end else if (r_sync[1] == r_line_f) r_cnt <= '0;
        else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_line_f <= r_sync[1];
            r_cnt    <= '0;
        end else r_cnt <= r_cnt + 1'b1;
    assign o_line_f = r_line_f;
`else
    assign o_line_f = r_sync[1];
`endif
endmodule

// File: rtl/io_input_line_capture.sv
// io_input_line_capture: arm/go triggered delay and width measurement of one input line.
// Debounce filter enabled by defining IO_IN_DEBOUNCE_EN.
module io_input_line_capture
    import io_line_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int DLY_W      = IO_DLY_W,
    parameter int WID_W      = IO_WID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rest_level,
    input  logic             i_arm,
    input  logic             i_go,
    input  logic [DLY_W-1:0] i_window,
    input  logic             i_line_in,
    input  logic             i_hard_stop,
    output logic [DLY_W-1:0] o_meas_delay,
    output logic [WID_W-1:0] o_meas_width,
    output logic             o_capture_complete,
    output logic             o_timed_out,
    output logic             o_width_sat,
    output logic             o_busy
);
    io_state_e        r_state, w_next;
    logic             w_line_f, w_rest, w_edge, w_tmo, w_sat, w_start;
    logic             r_seen, r_tmo, r_sat;
    logic [DLY_W-1:0] r_dly, r_delay, w_dly_inc;
    logic [WID_W-1:0] r_wid, r_width;

    io_input_sync_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
        .clk          (clk),
        .rst          (rst),
        .i_rest_level (i_rest_level),
        .i_line_in    (i_line_in),
        .o_line_f     (w_line_f)
    );

    // Delays count edges since go, so the edge-sampling cycle itself is included.
    assign w_dly_inc = r_dly + 1'b1;
    assign w_rest    = w_line_f == i_rest_level;
    assign w_edge    = r_seen && !w_rest;
    assign w_tmo     = |i_window && w_dly_inc == i_window;
    assign w_sat     = &r_wid;
    assign w_start   = (r_state == IDLE || r_state == ARMED) && w_next == WAIT;

    always_ff @(posedge clk)
        r_state <= !rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (i_hard_stop || !i_arm) w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = i_go ? WAIT : ARMED;
                ARMED:   w_next = i_go ? WAIT : ARMED;
                WAIT:    w_next = w_edge ? ACTIVE : w_tmo ? DONE : WAIT;
                ACTIVE:  w_next = (w_rest || w_sat) ? DONE : ACTIVE;
                default: w_next = DONE;
            endcase
    end

    always_comb begin
        o_busy             = r_state == WAIT || r_state == ACTIVE;
        o_capture_complete = r_state == DONE;
    end

    always_ff @(posedge clk)
        if (!rst || i_hard_stop || !i_arm) begin
            r_dly   <= '0;
            r_wid   <= '0;
            r_delay <= '0;
            r_width <= '0;
            r_tmo   <= 1'b0;
            r_sat   <= 1'b0;
            r_seen  <= 1'b0;
        end else if (w_start) begin
            r_dly   <= '0;
            r_wid   <= '0;
            r_delay <= '0;
            r_width <= '0;
            r_tmo   <= 1'b0;
            r_sat   <= 1'b0;
            r_seen  <= w_rest;
        end else if (r_state == WAIT) begin
            r_dly  <= w_dly_inc;
            r_seen <= r_seen | w_rest;
            if (w_edge) begin
                r_delay <= w_dly_inc;
                r_wid   <= WID_W'(1);
            end else if (w_tmo) begin
                r_tmo   <= 1'b1;
                r_delay <= i_window;
            end
        end else if (r_state == ACTIVE) begin
            r_wid <= r_wid + 1'b1;
            if (w_rest) r_width <= r_wid;
            else if (w_sat) begin
                r_sat   <= 1'b1;
                r_width <= '1;
            end
        end

    assign o_meas_delay = r_delay;
    assign o_meas_width = r_width;
    assign o_timed_out  = r_tmo;
    assign o_width_sat  = r_sat;
endmodule

// File: tb/tb_io_input_line_capture.sv
// tb_io_input_line_capture: directed scoreboard bench for io_input_line_capture.
module tb_io_input_line_capture;
    localparam int DLY_W = 21;
    localparam int WID_W = 11;
    localparam int DEB   = 4;
`ifdef IO_IN_DEBOUNCE_EN
    localparam int LAT  = 2 + DEB;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        int d;
        int w;
        bit t;
        bit s;
    } exp_t;

    logic             clk = 1'b0, rst = 1'b0, rest_level = 1'b0, arm = 1'b0, go = 1'b0;
    logic             line_in = 1'b0, hard_stop = 1'b0;
    logic [DLY_W-1:0] window = '0;
    logic [DLY_W-1:0] meas_delay;
    logic [WID_W-1:0] meas_width;
    logic             cc, tmo, sat, busy;
    logic             cc_d = 1'b0;
    int               tests = 0, fails = 0, cyc = 0, go_cyc = 0;
    exp_t             q[$];
    exp_t             e;

    io_input_line_capture #(.DEB_CYCLES(DEB), .DLY_W(DLY_W), .WID_W(WID_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_rest_level       (rest_level),
        .i_arm              (arm),
        .i_go               (go),
        .i_window           (window),
        .i_line_in          (line_in),
        .i_hard_stop        (hard_stop),
        .o_meas_delay       (meas_delay),
        .o_meas_width       (meas_width),
        .o_capture_complete (cc),
        .o_timed_out        (tmo),
        .o_width_sat        (sat),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {meas_delay, meas_width, cc, tmo, sat, busy}, 64'd0);
    endtask

    // Monitor: every rising capture_complete is matched against the next expected result.
    always @(negedge clk) begin
        if (cc && !cc_d) begin
            if (q.size() == 0) chk("unexpected_capture", 1, 0);
            else begin
                e = q.pop_front();
                chk("meas_delay", meas_delay, e.d);
                chk("meas_width", meas_width, e.w);
                chk("timed_out", tmo, e.t);
                chk("width_sat", sat, e.s);
                chk("done_latency", cyc - go_cyc, e.d + e.w);
            end
        end
        cc_d <= cc;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start();
        arm = 1'b1;
        go  = 1'b1;
        tick();
        go_cyc = cyc;
        go = 1'b0;
    endtask

    task automatic wait_cc(input int budget);
        int k = 0;
        while (!cc && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("capture_seen", cc, 1);
        tick();
    endtask

    task automatic release_arm(input string name);
        arm = 1'b0;
        tick();
        @(negedge clk);
        chk_idle(name);
        tick();
    endtask

    initial begin
        tick(3);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        tick(10);

        // Nominal capture, then DONE holds and ignores go.
        q.push_back('{100 + LAT, 50, 1'b0, 1'b0});
        start();
        tick(99);
        line_in = 1'b1;
        tick(50);
        line_in = 1'b0;
        wait_cc(100);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(2);
        @(negedge clk);
        chk("done_hold", {cc, meas_delay}, {1'b1, DLY_W'(100 + LAT)});
        release_arm("nominal_release");

        window = DLY_W'(200);
        q.push_back('{200, 0, 1'b1, 1'b0});
        start();
        wait_cc(300);
        release_arm("timeout_release");

        window = '0;
        start();
        tick(500);
        @(negedge clk);
        chk("no_window_busy", {busy, cc}, 2'b10);
        release_arm("no_window_release");

        // Short pulse: filtered out with debounce, measured without.
        if (!FILT) q.push_back('{30 + LAT, 3, 1'b0, 1'b0});
        start();
        tick(29);
        line_in = 1'b1;
        tick(3);
        line_in = 1'b0;
        tick(30);
        @(negedge clk);
        chk("glitch_state", {busy, cc}, FILT ? 2'b10 : 2'b01);
        release_arm("glitch_release");

        line_in = 1'b1;
        tick(20);
        q.push_back('{40 + LAT, 10, 1'b0, 1'b0});
        start();
        tick(19);
        line_in = 1'b0;
        tick(20);
        line_in = 1'b1;
        tick(10);
        line_in = 1'b0;
        wait_cc(50);
        release_arm("preactive_release");

        rest_level = 1'b1;
        line_in = 1'b1;
        tick(20);
        q.push_back('{10 + LAT, 2047, 1'b0, 1'b1});
        start();
        tick(9);
        line_in = 1'b0;
        tick(3000);
        line_in = 1'b1;
        wait_cc(50);
        release_arm("sat_release");
        tick(20);

        start();
        tick(9);
        line_in = 1'b0;
        tick(20);
        @(negedge clk);
        chk("hs_active_busy", busy, 1);
        hard_stop = 1'b1;
        tick();
        @(negedge clk);
        chk_idle("hard_stop");
        hard_stop = 1'b0;
        arm = 1'b0;
        line_in = 1'b1;
        tick(20);

        start();
        tick(9);
        line_in = 1'b0;
        tick(20);
        @(negedge clk);
        chk("drop_active_busy", busy, 1);
        arm = 1'b0;
        tick();
        @(negedge clk);
        chk_idle("arm_drop");
        line_in = 1'b1;
        tick(20);

        start();
        tick(10);
        @(negedge clk);
        chk("rst_wait_busy", busy, 1);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_idle("rst_mid_wait");
        rst = 1'b1;
        arm = 1'b0;
        tick(5);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/io_input_line_capture.md
# io_input_line_capture

Arm/go-triggered measurement channel for one digital input line: the receive-side counterpart of the output-line pulse generator. After arm and go, it waits for the line to leave its rest level, then records delay (go → active edge) and width (active duration). The generator produces a delay/duration pulse from the same arm/go/hard-stop sequencing; this block measures one. One instance per input pin in the I/O bank. The controller reads results after `capture_complete`.

## Interface
- `DEB_CYCLES`, default 4: consecutive equal samples required by the debounce filter (≥1).
- `DLY_W`, default 21: delay counter and window width.
- `WID_W`, default 11: width counter width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `rest_level` in 1: idle level of the line; active level = ~rest_level.
- `arm` in 1: arm request; level-held for the whole capture.
- `go` in 1: start; accepted only while armed or together with arm.
- `window` in DLY_W: timeout in clocks for the edge wait; 0 = no timeout.
- `line_in` in 1: asynchronous pin input.
- `hard_stop` in 1: abort; highest functional priority.
- `meas_delay` out DLY_W: clocks from go acceptance to filtered active edge.
- `meas_width` out WID_W: clocks the filtered line stayed active.
- `capture_complete` out 1: result valid; held until arm drops.
- `timed_out` out 1: window expired with no edge.
- `width_sat` out 1: width counter saturated at all-ones.
- `busy` out 1: high in WAIT and ACTIVE.

## Operation
- Input path: 2-flop synchronizer, then debounce filter, producing `line_f`. Sync and filter flops reset to `rest_level`.
- States: IDLE, ARMED, WAIT, ACTIVE, DONE.
- IDLE: `arm`=1, `go`=0 → ARMED. `arm`=1, `go`=1 → WAIT.
- ARMED: `go`=1 → WAIT. `arm`=0 → IDLE.
- Entering WAIT: clear `dly_cnt`, `wid_cnt`, the results, and the flags. Set `seen_rest` = (`line_f` == `rest_level`).
- WAIT:
  - `dly_cnt` increments every cycle.
  - If `line_f` == `rest_level`, set `seen_rest`.
  - If `seen_rest` and `line_f` != `rest_level`: `meas_delay` ← `dly_cnt`, go to ACTIVE.
  - A line already active at go is ignored until it returns to rest.
  - If `window`≠0 and `dly_cnt` == `window`-1 with no edge: `timed_out`=1, `meas_delay`=`window`, `meas_width`=0 → DONE. On the same cycle, the edge wins.
- ACTIVE:
  - `wid_cnt` increments, counting the first active cycle as 1.
  - Filtered return to rest: `meas_width` ← `wid_cnt` → DONE.
  - `wid_cnt` reaching all-ones: `width_sat`=1, `meas_width`=all-ones → DONE.
  - No timeout applies in ACTIVE.
- DONE: `capture_complete`=1, results frozen. `arm`=0 → IDLE, clearing `capture_complete`. `go` is ignored.
- `arm` dropping in WAIT or ACTIVE → IDLE, no result, `capture_complete` stays 0.
- `hard_stop`=1 (any state): next state IDLE; counters, results, and flags cleared to 0. While held, all inputs are ignored.
- `rest_level` must be static while `busy`; changing it mid-capture is unsupported.

## Timing
- Reset (`rst`=0 at an edge): state IDLE; all outputs 0; sync/filter flops = `rest_level`.
- Pin-to-`line_f` latency `LAT` = 2 + `DEB_CYCLES` clocks with the filter, 2 without.
- `meas_delay` = N + `LAT`, where N = clocks from the go-sampling edge to the first edge sampling the pin active.
- `meas_width` is exact for pulses ≥ `DEB_CYCLES`, because both edges carry equal latency.
- Pulses shorter than `DEB_CYCLES` are filtered out entirely.
- Results and `capture_complete` rise on the same edge as the DONE entry; they are registered with no further latency.
- Priority order: `rst` > `hard_stop` > `arm` drop > state logic.

## Configuration
- `IO_IN_DEBOUNCE_EN` defined: filter active. `line_f` changes only after `DEB_CYCLES` consecutive equal synchronized samples.
- `IO_IN_DEBOUNCE_EN` undefined: `line_f` = synchronizer output, `LAT`=2, `DEB_CYCLES` unused.

## Structure
- Shared package `io_line_pkg`: state enum (IDLE/ARMED/WAIT/ACTIVE/DONE) and default width constants `IO_DLY_W`=21 and `IO_WID_W`=11. These constants are shared with the output-line generator.
- Sub-module `io_input_sync_filter`: synchronizer plus `IO_IN_DEBOUNCE_EN`-gated filter; outputs `line_f`.

## Test plan
All scenarios use `DEB_CYCLES`=4 with the macro on (`LAT`=6) unless stated.
- Nominal: `rest_level`=0, arm, go, pin high at N=100 for 50 clocks → `meas_delay`=106, `meas_width`=50, `capture_complete`=1, flags 0; `arm`=0 → all clear next cycle.
- Timeout: `window`=200, pin never toggles → `timed_out`=1, `meas_delay`=200 exactly 200 clocks after go; `window`=0 → never completes.
- Glitch and pre-active line: 3-clock pulse → ignored. Line already high at go, low at 20, high at 40 for 10 → `meas_delay`=46, `meas_width`=10.
- Saturation and inversion: `rest_level`=1, line low for 3000 clocks → `width_sat`=1, `meas_width`=2047.
- Abort: `hard_stop` or `arm`=0 mid-ACTIVE → IDLE next cycle, outputs 0, no `capture_complete`. `rst`=0 mid-WAIT → all outputs 0.
- Macro off: nominal scenario → `meas_delay`=102; a 3-clock pulse is now captured with `meas_width`=3.
